reg_rtl: RTL and testbench

REG_RTL -- requirements
Module: reg_rtl

---
 rtl/regfile_pkg.sv | 15 +
 rtl/reg_rtl.sv | 43 ++++
 tb/tb_reg_rtl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing for the register file and anything that talks to it.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

    // Default data width of each register entry, in bits.
    localparam int REG_DATA_W = 16;

    // Default address width; depth is derived from it.
    localparam int REG_ADDR_W = 4;

    // Number of entries addressed by REG_ADDR_W bits.
    localparam int REG_DEPTH  = 2 ** REG_ADDR_W;

endpackage

// File: rtl/reg_rtl.sv
// Register file with one synchronous write port and two combinational read ports.
// Latency: writes land on the rising clk edge; reads are zero-cycle combinational.
// Backpressure: none; a write is accepted every cycle en is high and rst is low.
module reg_rtl
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              en,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Entry 0 is an ordinary register; every address in range is backed by storage.
    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array: reset clears every entry at once and wins over a coincident write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Two independent read muxes; no bypass, so a same-address write shows after the edge.
    always_comb begin
        rd_data1 = mem[rd_addr1];
        rd_data2 = mem[rd_addr2];
    end

endmodule

// File: tb/tb_reg_rtl.sv
// Directed self-checking bench for reg_rtl with an expected-value queue.
// Latency: checks reads combinationally and writes one edge after drive.
// Backpressure: n/a.
module tb_reg_rtl;
    import regfile_pkg::*;

    localparam int DW = REG_DATA_W;
    localparam int AW = REG_ADDR_W;

    logic          clk;
    logic          rst;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_addr;
    logic          en;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic [DW-1:0] rd_data1;
    logic [DW-1:0] rd_data2;

    int checks;
    int errors;

    logic [DW-1:0] exp_q [$];
    string         tag_q [$];

    reg_rtl #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_addr  (wr_addr),
        .en       (en),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input string tag, input logic [DW-1:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [DW-1:0] obs);
        logic [DW-1:0] e;
        string         t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=%h expected=queued_value", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $display("FAIL %s observed=%h expected=%h", t, obs, e);
                $error("%s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        en      = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        en      = 1'b0;
    endtask

    task automatic read2(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        rd_addr1 = a1;
        rd_addr2 = a2;
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        en       = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr1 = '0;
        rd_addr2 = '0;

        // Reset state: every address reads zero on both ports.
        tick();
        for (int a = 0; a < REG_DEPTH; a++) begin
            read2(AW'(a), AW'(REG_DEPTH - 1 - a));
            push($sformatf("rst_p1_a%0d", a), 16'h0000);
            check(rd_data1);
            push($sformatf("rst_p2_a%0d", REG_DEPTH - 1 - a), 16'h0000);
            check(rd_data2);
        end

        @(negedge clk);
        rst = 1'b0;
        #1;

        // Single write, both ports on the same entry.
        write(4'd1, 16'hB274);
        read2(4'd1, 4'd1);
        push("w1_p1", 16'hB274); check(rd_data1);
        push("w1_p2", 16'hB274); check(rd_data2);

        // Two more writes, mixed port addressing.
        write(4'd2, 16'hEA7C);
        write(4'd3, 16'h8277);
        read2(4'd1, 4'd2);
        push("r12_p1", 16'hB274); check(rd_data1);
        push("r12_p2", 16'hEA7C); check(rd_data2);
        read2(4'd3, 4'd1);
        push("r31_p1", 16'h8277); check(rd_data1);
        push("r31_p2", 16'hB274); check(rd_data2);

        // Disabled write for two cycles must not touch storage.
        en = 1'b0; wr_addr = 4'd3; wr_data = 16'hFFFF;
        tick(); tick();
        read2(4'd3, 4'd3);
        push("en0_a3", 16'h8277); check(rd_data1);

        // Unknown address/data while disabled must not corrupt anything.
        wr_addr = 'x; wr_data = 'x;
        tick();
        read2(4'd1, 4'd2);
        push("xin_a1", 16'hB274); check(rd_data1);
        push("xin_a2", 16'hEA7C); check(rd_data2);
        wr_addr = '0; wr_data = '0;

        // Read-during-write: old value before the edge, new value after.
        read2(4'd5, 4'd5);
        en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234;
        #1;
        push("rdw_pre_p1", 16'h0000); check(rd_data1);
        push("rdw_pre_p2", 16'h0000); check(rd_data2);
        tick();
        en = 1'b0;
        push("rdw_post_p1", 16'h1234); check(rd_data1);
        push("rdw_post_p2", 16'h1234); check(rd_data2);

        // Boundary addresses 0 and 15 are real storage; neighbours stay clear.
        write(4'd0, 16'h0F0F);
        write(4'd15, 16'hC3A5);
        read2(4'd0, 4'd15);
        push("a0",  16'h0F0F); check(rd_data1);
        push("a15", 16'hC3A5); check(rd_data2);
        read2(4'd14, 4'd4);
        push("a14", 16'h0000); check(rd_data1);
        push("a4",  16'h0000); check(rd_data2);

        // Asynchronous reset between edges clears outputs before any edge.
        read2(4'd1, 4'd3);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        push("arst_p1", 16'h0000); check(rd_data1);
        push("arst_p2", 16'h0000); check(rd_data2);

        // Write attempted under reset is discarded.
        en = 1'b1; wr_addr = 4'd4; wr_data = 16'hAAAA;
        tick();
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
        read2(4'd4, 4'd15);
        push("rst_wr_a4", 16'h0000); check(rd_data1);
        push("rst_a15",   16'h0000); check(rd_data2);

        // First write after reset release is accepted on the next edge.
        write(4'd6, 16'h5A5A);
        read2(4'd6, 4'd1);
        push("post_rst_a6", 16'h5A5A); check(rd_data1);
        push("post_rst_a1", 16'h0000); check(rd_data2);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
